// File: rtl/kyber_polyop_scheduler_if.sv
// -----------------------------------------------------------------------------
// kyber_polyop_scheduler_if
//   Bundles the requester handshake, the operand/result BRAM strobes and the
//   add/sub datapath hookup of the poly add/sub scheduler.
//   slave  : the scheduler side (takes requests and dp_result, drives the rest)
//   master : the Enc/Dec FSM + BRAM + datapath side
// Signals
//   req_valid/req_sub/req_a_base/req_b_base/req_w_base : per-requester job request
//   grant/done/busy                                   : arbitration status
//   rd_en/a_rd_addr/b_rd_addr                          : shared A/B read port
//   dp_sub/dp_result                                   : datapath op select / result
//   wr_en/wr_addr/wr_data                              : result write port
// -----------------------------------------------------------------------------
interface kyber_polyop_scheduler_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 128
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_sub;
  logic [NREQ*AW-1:0] req_a_base;
  logic [NREQ*AW-1:0] req_b_base;
  logic [NREQ*AW-1:0] req_w_base;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic               rd_en;
  logic [AW-1:0]      a_rd_addr;
  logic [AW-1:0]      b_rd_addr;
  logic               dp_sub;
  logic [DW-1:0]      dp_result;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;

  modport slave (
    input  req_valid, req_sub, req_a_base, req_b_base, req_w_base, dp_result,
    output grant, done, busy, rd_en, a_rd_addr, b_rd_addr, dp_sub,
           wr_en, wr_addr, wr_data
  );

  modport master (
    output req_valid, req_sub, req_a_base, req_b_base, req_w_base, dp_result,
    input  grant, done, busy, rd_en, a_rd_addr, b_rd_addr, dp_sub,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/kyber_polyop_scheduler.sv
// -----------------------------------------------------------------------------
// kyber_polyop_scheduler
//   Shares one coefficient-wise poly add/sub datapath among NREQ requesters
//   (0 EncBp0, 1 EncBp1, 2 EncV, 3 DecMp). A granted job streams WORDS packed
//   words from operand BRAMs A and B, registers the datapath result into the
//   output BRAM and pulses done for the requester.
// Ports
//   clk  : clock, all logic on posedge
//   rst  : synchronous reset, active-high (aborts any job, no done)
//   bus  : kyber_polyop_scheduler_if.slave (requests, BRAM ports, datapath)
// Build option
//   KYBER_SCHED_RR_EN : round-robin arbitration with a rotating pointer.
//                       Undefined: fixed priority, lowest index wins.
// -----------------------------------------------------------------------------
module kyber_polyop_scheduler #(
  parameter int NREQ   = 4,
  parameter int AW     = 8,
  parameter int DW     = 128,
  parameter int WORDS  = 32,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  kyber_polyop_scheduler_if.slave  bus
);

  localparam int IW = (NREQ  > 1) ? $clog2(NREQ)  : 1;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [IW-1:0]     gidx_reg;
  logic [IW-1:0]     win_idx;
  logic              sub_reg;
  logic [AW-1:0]     a_base_reg, b_base_reg, w_base_reg;
  logic [KW-1:0]     k_reg;      // read word index
  logic [KW-1:0]     wk_reg;     // write word index
  logic [RD_LAT-1:0] vpipe_reg;  // rd_en delayed to line up with BRAM data
  logic              wr_en_reg;
  logic [AW-1:0]     wr_addr_reg;
  logic [DW-1:0]     wr_data_reg;
  logic              any_req;
  logic              in_job;

  logic [AW-1:0] a_base_arr [NREQ];
  logic [AW-1:0] b_base_arr [NREQ];
  logic [AW-1:0] w_base_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_base_arr[gi] = bus.req_a_base[gi*AW +: AW];
      assign b_base_arr[gi] = bus.req_b_base[gi*AW +: AW];
      assign w_base_arr[gi] = bus.req_w_base[gi*AW +: AW];
    end
  endgenerate

  assign any_req = |bus.req_valid;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef KYBER_SCHED_RR_EN
  logic [IW-1:0] ptr_reg;
  logic [IW:0]   cand;

  // Walk offsets from far to near so the requester closest to ptr wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_reg} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (bus.req_valid[cand[IW-1:0]]) begin
        win_idx = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (state_reg == ST_DONE) begin
      ptr_reg <= (gidx_reg == IW'(NREQ - 1)) ? '0 : gidx_reg + IW'(1);
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win_idx = IW'(i);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (any_req)                  state_next = ST_ISSUE;
      ST_ISSUE: if (k_reg == KW'(WORDS - 1))  state_next = ST_DRAIN;
      // Reads still in flight inside the BRAM keep us here; the final
      // registered write lands in the same cycle we leave.
      ST_DRAIN: if (vpipe_reg == '0)          state_next = ST_DONE;
      ST_DONE:                                state_next = ST_IDLE;
      default:                                state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, job latches, read counter and write pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      gidx_reg    <= '0;
      sub_reg     <= 1'b0;
      a_base_reg  <= '0;
      b_base_reg  <= '0;
      w_base_reg  <= '0;
      k_reg       <= '0;
      wk_reg      <= '0;
      vpipe_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (state_reg == ST_IDLE) begin
        if (any_req) begin
          gidx_reg   <= win_idx;
          sub_reg    <= bus.req_sub[win_idx];
          a_base_reg <= a_base_arr[win_idx];
          b_base_reg <= b_base_arr[win_idx];
          w_base_reg <= w_base_arr[win_idx];
        end
        k_reg  <= '0;
        wk_reg <= '0;
      end else if (state_reg == ST_ISSUE) begin
        k_reg <= k_reg + KW'(1);
      end

      vpipe_reg[0] <= (state_reg == ST_ISSUE);
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe_reg[i] <= vpipe_reg[i-1];
      end

      // The pipe tail is high exactly when dp_result reflects word wk_reg.
      wr_en_reg <= vpipe_reg[RD_LAT-1];
      if (vpipe_reg[RD_LAT-1]) begin
        wr_data_reg <= bus.dp_result;
        wr_addr_reg <= w_base_reg + AW'(wk_reg);
        wk_reg      <= wk_reg + KW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_job = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign bus.grant[gi] = in_job && (gidx_reg == IW'(gi));
      assign bus.done[gi]  = (state_reg == ST_DONE) && (gidx_reg == IW'(gi));
    end
  endgenerate

  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.rd_en     = (state_reg == ST_ISSUE);
  // Address adders wrap modulo 2^AW by construction.
  assign bus.a_rd_addr = bus.rd_en ? a_base_reg + AW'(k_reg) : '0;
  assign bus.b_rd_addr = bus.rd_en ? b_base_reg + AW'(k_reg) : '0;
  assign bus.dp_sub    = bus.busy & sub_reg;
  assign bus.wr_en     = wr_en_reg;
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.wr_data   = wr_data_reg;

endmodule

// File: tb/tb_kyber_polyop_scheduler.sv
// -----------------------------------------------------------------------------
// tb_kyber_polyop_scheduler
//   Directed bench: one scheduler with RD_LAT=1 and one with RD_LAT=3, each with
//   a small BRAM read model and the mod-q add/sub datapath in front of it.
// -----------------------------------------------------------------------------
module tb_kyber_polyop_scheduler;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 128;
  localparam int Q    = 3329;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic                sel = 1'b0;  // 0: RD_LAT=1 instance, 1: RD_LAT=3 instance
  logic [NREQ-1:0]     req_v = '0;
  logic [NREQ-1:0]     req_s = '0;
  logic [NREQ*AW-1:0]  a_flat = '0, b_flat = '0, w_flat = '0;

  kyber_polyop_scheduler_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus1 ();
  kyber_polyop_scheduler_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus3 ();

  kyber_polyop_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW), .WORDS(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  kyber_polyop_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW), .WORDS(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  // ---- operand contents and datapath model ----
  function automatic logic [127:0] word_a(input logic [7:0] addr);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[16*j +: 16] = 16'((int'(addr) * 37 + j * 101) % Q);
    return r;
  endfunction

  function automatic logic [127:0] word_b(input logic [7:0] addr);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[16*j +: 16] = 16'((int'(addr) * 53 + j * 211 + 1000) % Q);
    return r;
  endfunction

  function automatic logic [127:0] dp_fn(input logic [127:0] x, input logic [127:0] y,
                                         input logic sub);
    logic [127:0] r;
    int xa, ya, v;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      xa = int'(x[16*j +: 16]);
      ya = int'(y[16*j +: 16]);
      v  = sub ? (xa - ya + Q) % Q : (xa + ya) % Q;
      r[16*j +: 16] = 16'(v);
    end
    return r;
  endfunction

  // ---- BRAM read pipelines ----
  logic [7:0] pa1, pb1;
  logic [7:0] pa3 [3];
  logic [7:0] pb3 [3];

  always @(posedge clk) begin
    pa1    <= bus1.a_rd_addr;
    pb1    <= bus1.b_rd_addr;
    pa3[0] <= bus3.a_rd_addr;
    pb3[0] <= bus3.b_rd_addr;
    pa3[1] <= pa3[0];
    pb3[1] <= pb3[0];
    pa3[2] <= pa3[1];
    pb3[2] <= pb3[1];
  end

  assign bus1.dp_result = dp_fn(word_a(pa1), word_b(pb1), bus1.dp_sub);
  assign bus3.dp_result = dp_fn(word_a(pa3[2]), word_b(pb3[2]), bus3.dp_sub);

  assign bus1.req_valid  = sel ? '0 : req_v;
  assign bus3.req_valid  = sel ? req_v : '0;
  assign bus1.req_sub    = req_s;
  assign bus3.req_sub    = req_s;
  assign bus1.req_a_base = a_flat;
  assign bus3.req_a_base = a_flat;
  assign bus1.req_b_base = b_flat;
  assign bus3.req_b_base = b_flat;
  assign bus1.req_w_base = w_flat;
  assign bus3.req_w_base = w_flat;

  // ---- observed side of the selected instance ----
  logic [NREQ-1:0] m_grant, m_done;
  logic            m_busy, m_rd_en, m_dp_sub, m_wr_en;
  logic [AW-1:0]   m_a_addr, m_b_addr, m_wr_addr;
  logic [DW-1:0]   m_wr_data;

  assign m_grant   = sel ? bus3.grant     : bus1.grant;
  assign m_done    = sel ? bus3.done      : bus1.done;
  assign m_busy    = sel ? bus3.busy      : bus1.busy;
  assign m_rd_en   = sel ? bus3.rd_en     : bus1.rd_en;
  assign m_dp_sub  = sel ? bus3.dp_sub    : bus1.dp_sub;
  assign m_wr_en   = sel ? bus3.wr_en     : bus1.wr_en;
  assign m_a_addr  = sel ? bus3.a_rd_addr : bus1.a_rd_addr;
  assign m_b_addr  = sel ? bus3.b_rd_addr : bus1.b_rd_addr;
  assign m_wr_addr = sel ? bus3.wr_addr   : bus1.wr_addr;
  assign m_wr_data = sel ? bus3.wr_data   : bus1.wr_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},   m_grant,   '0);
    check({tag, "_done"},    m_done,    '0);
    check({tag, "_busy"},    m_busy,    '0);
    check({tag, "_rd_en"},   m_rd_en,   '0);
    check({tag, "_a_addr"},  m_a_addr,  '0);
    check({tag, "_b_addr"},  m_b_addr,  '0);
    check({tag, "_dp_sub"},  m_dp_sub,  '0);
    check({tag, "_wr_en"},   m_wr_en,   '0);
    check({tag, "_wr_addr"}, m_wr_addr, '0);
    check({tag, "_wr_data"}, m_wr_data, '0);
  endtask

  task automatic set_slice(input int g, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] w, input logic sub);
    a_flat[g*AW +: AW] = a;
    b_flat[g*AW +: AW] = b;
    w_flat[g*AW +: AW] = w;
    req_s[g]           = sub;
  endtask

  // Steps negedges until grant appears (bounded); n = cycles waited.
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (m_grant == '0) check("no_stray_done", m_done, '0);
    end while (m_grant == '0 && n < 60);
  endtask

  // Follows one job from its first granted cycle to its done cycle; returns at
  // the negedge of the done cycle.
  task automatic run_job(input int g, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] w, input logic sub, input int lat,
                         input int exp_wait, input bit drop,
                         output logic [127:0] first_wr);
    int          n, k;
    logic [3:0]  oh;
    logic [7:0]  ea, eb, ew;
    bit          exp_rd, exp_wr, exp_done;
    oh       = 4'(1 << g);
    first_wr = '0;
    wait_grant(n);
    if (m_grant == '0) begin
      check("grant_timeout", 1'b0, 1'b1);
      return;
    end
    check("grant_wait", n, exp_wait);
    for (int c = 0; c <= 32 + lat + 1; c++) begin
      if (c > 0) @(negedge clk);
      exp_rd   = (c < 32);
      exp_wr   = (c >= lat + 1) && (c <= lat + 32);
      exp_done = (c == 32 + lat + 1);
      check($sformatf("grant@%0d", c), m_grant, exp_done ? 4'b0 : oh);
      check($sformatf("done@%0d", c),  m_done,  exp_done ? oh : 4'b0);
      check($sformatf("busy@%0d", c),  m_busy,  1'b1);
      check($sformatf("rd_en@%0d", c), m_rd_en, exp_rd);
      check($sformatf("wr_en@%0d", c), m_wr_en, exp_wr);
      if (!exp_done) check($sformatf("dp_sub@%0d", c), m_dp_sub, sub);
      if (exp_rd) begin
        ea = a + 8'(c);
        eb = b + 8'(c);
        check($sformatf("a_addr@%0d", c), m_a_addr, ea);
        check($sformatf("b_addr@%0d", c), m_b_addr, eb);
      end
      if (exp_wr) begin
        k  = c - lat - 1;
        ea = a + 8'(k);
        eb = b + 8'(k);
        ew = w + 8'(k);
        check($sformatf("wr_addr@%0d", c), m_wr_addr, ew);
        check($sformatf("wr_data@%0d", c), m_wr_data, dp_fn(word_a(ea), word_b(eb), sub));
        if (k == 0) first_wr = m_wr_data;
      end
      if (exp_done && drop) req_v[g] = 1'b0;
    end
    $display("job req=%0d lat=%0d a=%h b=%h w=%h sub=%0d grant_wait=%0d",
             g, lat, a, b, w, sub, n);
  endtask

  logic [127:0] fw;
  int           order [4];
  int           nw;

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clk);
    sel = 1'b0;
    check_all_zero("rst1");
    sel = 1'b1;
    check_all_zero("rst3");
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // ---- single job: A-B, a=0 b=32 w=64 ----
    set_slice(0, 8'h00, 8'h20, 8'h40, 1'b1);
    req_v = 4'b0001;
    run_job(0, 8'h00, 8'h20, 8'h40, 1'b1, 1, 1, 1'b1, fw);
    // A(0)={..,101,0}, B(32)={..,2907,2696}: 0-2696+q=633, 101-2907+q=523
    check("hand_coef0", fw[15:0],  16'd633);
    check("hand_coef1", fw[31:16], 16'd523);

    // ---- contention: 1010 -> 1 then 3 in either build ----
    @(negedge clk);
    set_slice(1, 8'h20, 8'h40, 8'h80, 1'b0);
    set_slice(3, 8'h10, 8'h50, 8'hA0, 1'b1);
    req_v = 4'b1010;
    run_job(1, 8'h20, 8'h40, 8'h80, 1'b0, 1, 1, 1'b1, fw);
    run_job(3, 8'h10, 8'h50, 8'hA0, 1'b1, 1, 2, 1'b1, fw);

    // ---- all four held continuously ----
    @(negedge clk);
    set_slice(0, 8'h00, 8'h20, 8'h40, 1'b0);
    set_slice(2, 8'h60, 8'h70, 8'hC0, 1'b1);
`ifdef KYBER_SCHED_RR_EN
    order = '{0, 1, 2, 3};
`else
    order = '{0, 0, 0, 0};
`endif
    req_v = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      run_job(order[j], a_flat[order[j]*AW +: AW], b_flat[order[j]*AW +: AW],
              w_flat[order[j]*AW +: AW], req_s[order[j]], 1, (j == 0) ? 1 : 2, 1'b0, fw);
    end
    req_v = 4'b0000;

    // ---- address wrap ----
    @(negedge clk);
    set_slice(0, 8'hF0, 8'h08, 8'hE8, 1'b0);
    req_v = 4'b0001;
    run_job(0, 8'hF0, 8'h08, 8'hE8, 1'b0, 1, 1, 1'b1, fw);

    // ---- reset at k=10, then re-grant from k=0 ----
    @(negedge clk);
    set_slice(0, 8'h05, 8'h06, 8'h07, 1'b1);
    req_v = 4'b0001;
    wait_grant(nw);
    check("rst_job_grant", m_grant, 4'b0001);
    repeat (10) @(negedge clk);
    check("rst_job_k10", m_a_addr, 8'h0F);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    run_job(0, 8'h05, 8'h06, 8'h07, 1'b1, 1, 1, 1'b1, fw);

    // ---- RD_LAT=3 instance ----
    @(negedge clk);
    sel = 1'b1;
    set_slice(0, 8'h30, 8'h60, 8'h90, 1'b1);
    req_v = 4'b0001;
    run_job(0, 8'h30, 8'h60, 8'h90, 1'b1, 3, 1, 1'b1, fw);
    @(negedge clk);
    check("lat3_idle_busy", m_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
